ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, data width.
REQ-002 The block SHALL have parameter AW, default 3, address width (2**AW words).
REQ-003 The block SHALL have parameter LOCK_MAX, default 16, maximum consecutive locked grants.
REQ-004 Port clk  input  1  single clock; all state updates on posedge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port reqN (N=0,1)  input  1  requester N wants one access this cycle.
REQ-007 Port wrN  input  1  1 = write, 0 = read; valid while reqN=1.
REQ-008 Port addrN  input  AW  word address; valid while reqN=1.
REQ-009 Port wdataN  input  DW  write data; valid while reqN=1 and wrN=1.
REQ-010 Port lockN  input  1  request to keep ownership after this access.
REQ-011 Port gntN  output  1  access accepted at the coming posedge; combinational from reqN and registered state.
REQ-012 Port rvalidN  output  1  registered; rdataN valid this cycle.
REQ-013 Port rdataN  output  DW  registered read data; holds last value when rvalidN=0.

Function
REQ-014 The block SHALL perform at most one RAM access per cycle: an access occurs at a posedge where reqN=1 and gntN=1.
REQ-015 At most one of gnt0/gnt1 SHALL be 1 in any cycle; gntN SHALL never be 1 while reqN=0.
REQ-016 Writes SHALL update the addressed word at the granting edge; a read of that word in the next cycle SHALL return the new value.
REQ-017 A granted read SHALL drive rdataN = mem[addrN] with rvalidN=1 exactly one cycle after the granting edge, rvalidN=0 otherwise; reads never assert the other requester's rvalid.
REQ-018 Arbitration SHALL be round-robin via a 1-bit last-grant pointer rr_ptr: on a conflict, grant goes to the requester not equal to rr_ptr; rr_ptr updates to the granted index after each grant.
REQ-019 A single requester SHALL be granted every cycle it requests (back-to-back, no bubbles).
REQ-020 Lock FSM states SHALL be UNLOCKED, LOCK0, LOCK1.
REQ-021 UNLOCKED -> LOCKn when requester n is granted with lockn=1; LOCKn -> UNLOCKED when requester n is granted with lockn=0, when reqn=0 in a cycle, or when lock_cnt reaches LOCK_MAX.
REQ-022 In LOCKn only requester n SHALL be granted; lock_cnt (width clog2(LOCK_MAX)+1) counts locked grants, clears on UNLOCKED entry.
REQ-023 On LOCK_MAX expiry the other requester, if requesting, SHALL win the next arbitration regardless of rr_ptr.
REQ-024 Address is unchecked: AW bits fully decode the array; no wrap logic required.

Reset
REQ-025 While rst_n=0: gnt0/gnt1=0, rvalid0/rvalid1=0, rdata0/rdata1=0, rr_ptr=1 (requester 0 wins first conflict), FSM=UNLOCKED, lock_cnt=0.
REQ-026 Memory contents SHALL NOT be reset; a read before any write returns undefined data.
REQ-027 Reset asserted mid-lock or mid-read SHALL abort immediately; the pending rvalid SHALL not appear after deassertion.

Configuration
REQ-028 Macro RAM_ARB_LOCK_EN defined: lock behaviour per REQ-020..023.
REQ-029 Macro RAM_ARB_LOCK_EN undefined: lockN ports remain but are ignored, FSM and lock_cnt are absent, pure round-robin applies.

Structure
REQ-030 Shared package ram_arb_pkg SHALL hold the lock-state enum (UNLOCKED/LOCK0/LOCK1) and default DW/AW/LOCK_MAX constants.
REQ-031 The storage array with synchronous write and registered read SHALL be sub-module ram_arb_mem; arbitration, FSM and return-data routing stay in ram_port_arbiter.

Verification
REQ-032 Reset, then req0 write addr 3 data 8'hA5, next cycle req0 read addr 3 -> gnt0=1 both cycles, rvalid0=1 with rdata0=8'hA5 one cycle after the read.
REQ-033 req0 and req1 both reading every cycle for 4 cycles -> grants 0,1,0,1; rvalid follows its owner one cycle later.
REQ-034 Same-cycle conflict: req0 write addr 5 = 8'h11, req1 write addr 5 = 8'h22, then read addr 5 -> 8'h22 (0 granted first, 1 second).
REQ-035 (RAM_ARB_LOCK_EN) req0 with lock0=1 continuously, req1 continuously -> gnt0 for 16 cycles, then gnt1 once, then lock again available to 0.
REQ-036 rst_n pulsed low during a granted read -> rvalid0 stays 0 after release; gnt0/gnt1 are 0 throughout reset.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the two-port RAM arbiter.
// Lock-state enum is only exercised when RAM_ARB_LOCK_EN is defined.
package ram_arb_pkg;

    localparam int DW_DEFAULT       = 8;
    localparam int AW_DEFAULT       = 3;
    localparam int LOCK_MAX_DEFAULT = 16;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK0    = 2'd1,
        LOCK1    = 2'd2
    } lock_state_e;

endpackage

// File: rtl/ram_arb_mem.sv
// Single-port storage array: synchronous write, registered read, no reset on contents.
module ram_arb_mem
    import ram_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a shared single-port RAM.
// Define RAM_ARB_LOCK_EN to enable the bounded ownership-lock FSM.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int AW       = AW_DEFAULT,
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,
    input  logic          req1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1
);

    // Handshake: an access takes place at the posedge where reqN && gntN; the
    // requester holds wrN/addrN/wdataN stable while reqN is high.
    logic          gnt0_c, gnt1_c;
    logic          rr_ptr_q, rr_ptr_d;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] hold0_q, hold1_q;
    logic [DW-1:0] mem_rdata;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

`ifdef RAM_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX) + 1;

    lock_state_e   state_q, state_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d, cnt_inc;

    // The lock owner already holds rr_ptr, so after expiry the other side wins.
    always_comb begin
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        cnt_inc    = lock_cnt_q + CW'(1);
        unique case (state_q)
            LOCK0: begin
                gnt0_c = req0;
                if (!req0 || !lock0 || int'(cnt_inc) >= LOCK_MAX) begin
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = cnt_inc;
                end
            end
            LOCK1: begin
                gnt1_c = req1;
                if (!req1 || !lock1 || int'(cnt_inc) >= LOCK_MAX) begin
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = cnt_inc;
                end
            end
            default: begin
                gnt0_c = req0 && (!req1 || rr_ptr_q);
                gnt1_c = req1 && (!req0 || !rr_ptr_q);
                if (gnt0_c && lock0 && LOCK_MAX > 1) begin
                    state_d    = LOCK0;
                    lock_cnt_d = CW'(1);
                end else if (gnt1_c && lock1 && LOCK_MAX > 1) begin
                    state_d    = LOCK1;
                    lock_cnt_d = CW'(1);
                end
            end
        endcase
        if (!rst_n) begin
            gnt0_c = 1'b0;
            gnt1_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UNLOCKED;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1 ^ (LOCK_MAX > 0);

    always_comb begin
        gnt0_c = rst_n && req0 && (!req1 || rr_ptr_q);
        gnt1_c = rst_n && req1 && (!req0 || !rr_ptr_q);
    end
`endif

    assign gnt0 = gnt0_c;
    assign gnt1 = gnt1_c;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt0_c) begin
            rr_ptr_d = 1'b0;
        end else if (gnt1_c) begin
            rr_ptr_d = 1'b1;
        end
    end

    assign mem_we    = (gnt0_c && wr0) || (gnt1_c && wr1);
    assign mem_re    = (gnt0_c && !wr0) || (gnt1_c && !wr1);
    assign mem_addr  = gnt1_c ? addr1 : addr0;
    assign mem_wdata = gnt1_c ? wdata1 : wdata0;

    ram_arb_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // The RAM output register is shared; each port keeps its own copy for hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            hold0_q   <= '0;
            hold1_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rvalid0_q <= gnt0_c && !wr0;
            rvalid1_q <= gnt1_c && !wr1;
            if (rvalid0_q) begin
                hold0_q <= mem_rdata;
            end
            if (rvalid1_q) begin
                hold1_q <= mem_rdata;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rvalid0_q ? mem_rdata : hold0_q;
    assign rdata1  = rvalid1_q ? mem_rdata : hold1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized scoreboard bench for ram_port_arbiter against a behavioural model.
// Lock expectations follow RAM_ARB_LOCK_EN when it is defined.
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int LOCK_MAX = 16;

  logic clk;
  logic rst_n;
  logic req0, wr0, lock0, req1, wr1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;

  ram_port_arbiter #(.DW(DW), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rdata0(rdata0),
    .rvalid1(rvalid1), .rdata1(rdata1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // counters and scoreboard
  int n_checks = 0;
  int n_pass = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int due_q0[$];
  int due_q1[$];
  logic [DW-1:0] last0, last1;

  // behavioural reference model
  logic [DW-1:0] mem_m [2**AW];
  int last_winner;
  int lock_owner;
  int lock_run;
  int expired_owner;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int model_winner();
    if (!rst_n) return -1;
`ifdef RAM_ARB_LOCK_EN
    if (lock_owner == 0) return req0 ? 0 : -1;
    if (lock_owner == 1) return req1 ? 1 : -1;
`endif
    if (req0 && req1) begin
      if (expired_owner >= 0) return 1 - expired_owner;
      return 1 - last_winner;
    end
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic model_update(input int w);
`ifdef RAM_ARB_LOCK_EN
    logic lk;
    lk = (w == 0) ? lock0 : lock1;
`endif
    if (w >= 0) begin
      last_winner = w;
      expired_owner = -1;
    end
`ifdef RAM_ARB_LOCK_EN
    if (lock_owner >= 0) begin
      if (w < 0 || !lk) begin
        lock_owner = -1;
      end else begin
        lock_run++;
        if (lock_run >= LOCK_MAX) begin
          lock_owner = -1;
          expired_owner = w;
        end
      end
    end else if (w >= 0 && lk) begin
      lock_run = 1;
      if (lock_run >= LOCK_MAX) expired_owner = w;
      else lock_owner = w;
    end
`endif
  endtask

  task automatic model_reset();
    last_winner = 1;
    lock_owner = -1;
    lock_run = 0;
    expired_owner = -1;
    exp_q0.delete();
    exp_q1.delete();
    due_q0.delete();
    due_q1.delete();
  endtask

  // driver tasks
  task automatic idle_inputs();
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0; lock0 = 1'b0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0; lock1 = 1'b0;
  endtask

  // One cycle with the inputs currently driven; grants are checked mid-cycle.
  task automatic step();
    int w;
    @(negedge clk);
    w = model_winner();
    check("gnt0", DW'(gnt0), DW'(w == 0));
    check("gnt1", DW'(gnt1), DW'(w == 1));
    if (w == 0) begin
      if (wr0) mem_m[addr0] = wdata0;
      else begin exp_q0.push_back(mem_m[addr0]); due_q0.push_back(cyc + 1); end
    end else if (w == 1) begin
      if (wr1) mem_m[addr1] = wdata1;
      else begin exp_q1.push_back(mem_m[addr1]); due_q1.push_back(cyc + 1); end
    end
    model_update(w);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt0", DW'(gnt0), '0);
      check("rst_gnt1", DW'(gnt1), '0);
      check("rst_rvalid0", DW'(rvalid0), '0);
      check("rst_rvalid1", DW'(rvalid1), '0);
      check("rst_rdata0", rdata0, '0);
      check("rst_rdata1", rdata1, '0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs(input int lock_pct);
    req0 = ($urandom_range(0, 3) != 0);
    wr0 = $urandom_range(0, 1) == 1;
    addr0 = AW'($urandom_range(0, 2**AW - 1));
    wdata0 = DW'($urandom);
    lock0 = ($urandom_range(0, 99) < lock_pct);
    req1 = ($urandom_range(0, 3) != 0);
    wr1 = $urandom_range(0, 1) == 1;
    addr1 = AW'($urandom_range(0, 2**AW - 1));
    wdata1 = DW'($urandom);
    lock1 = ($urandom_range(0, 99) < lock_pct);
  endtask

  // monitor: checks read returns on their due cycle and hold value otherwise
  always @(negedge clk) begin
    if (!rst_n) begin
      last0 = '0;
      last1 = '0;
    end else begin
      logic e0, e1;
      e0 = (due_q0.size() > 0) && (due_q0[0] == cyc);
      e1 = (due_q1.size() > 0) && (due_q1[0] == cyc);
      check("rvalid0", DW'(rvalid0), DW'(e0));
      check("rvalid1", DW'(rvalid1), DW'(e1));
      if (e0) begin
        last0 = exp_q0.pop_front();
        void'(due_q0.pop_front());
        check("rdata0", rdata0, last0);
      end else begin
        check("rdata0_hold", rdata0, last0);
      end
      if (e1) begin
        last1 = exp_q1.pop_front();
        void'(due_q1.pop_front());
        check("rdata1", rdata1, last1);
      end else begin
        check("rdata1_hold", rdata1, last1);
      end
    end
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #3;
    do_reset();

    // conflicting writes to addr 5, then read back
    req0 = 1; wr0 = 1; addr0 = 3'd5; wdata0 = 8'h11;
    req1 = 1; wr1 = 1; addr1 = 3'd5; wdata1 = 8'h22;
    step();
    req0 = 0;
    step();
    idle_inputs();
    req0 = 1; wr0 = 0; addr0 = 3'd5;
    step();

    // write then immediate read of addr 3
    idle_inputs();
    req0 = 1; wr0 = 1; addr0 = 3'd3; wdata0 = 8'hA5;
    step();
    wr0 = 0;
    step();
    idle_inputs();
    step();

    // fill the array so every later read is defined
    for (int a = 0; a < 2**AW; a++) begin
      idle_inputs();
      req1 = 1; wr1 = 1; addr1 = AW'(a); wdata1 = DW'($urandom);
      step();
    end

    // both reading every cycle
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      req0 = 1; addr0 = AW'($urandom_range(0, 2**AW - 1));
      req1 = 1; addr1 = AW'($urandom_range(0, 2**AW - 1));
      step();
    end

    // requester 0 holding lock against a continuous requester 1
    for (int i = 0; i < 40; i++) begin
      idle_inputs();
      req0 = 1; lock0 = 1; addr0 = AW'($urandom_range(0, 2**AW - 1));
      req1 = 1; addr1 = AW'($urandom_range(0, 2**AW - 1));
      step();
    end

    for (int i = 0; i < 300; i++) begin
      rand_inputs(50);
      step();
    end
    for (int i = 0; i < 150; i++) begin
      rand_inputs(95);
      req0 = 1;
      step();
    end

    // reset pulsed while a granted read is in flight
    idle_inputs();
    req0 = 1; wr0 = 0; addr0 = 3'd3;
    step();
    rst_n = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check("midrst_gnt0", DW'(gnt0), '0);
      check("midrst_gnt1", DW'(gnt1), '0);
      check("midrst_rvalid0", DW'(rvalid0), '0);
    end
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_rvalid0", DW'(rvalid0), '0);
      step();
    end

    for (int i = 0; i < 100; i++) begin
      rand_inputs(60);
      step();
    end

    idle_inputs();
    repeat (3) step();
    check("exp_q0_drained", DW'(exp_q0.size()), '0);
    check("exp_q1_drained", DW'(exp_q1.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
